// File: rtl/alu_share_arb.sv
// Two-port round-robin front end for a shared 16-bit logic/add unit.
// Multiply reuses the adder as a WIDTH-step shift-add sequence.
module alu_share_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic [1:0]       resp_flags,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL
  } state_t;

  state_t state, state_n;

  logic               prio;
  logic               own;
  logic               mdone;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               idle;
  logic               take0;
  logic               take1;
  logic               take;
  logic [2:0]         in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2*WIDTH-1:0] ax;
  logic [2*WIDTH-1:0] part;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               cy;

  assign idle       = (state == IDLE);
  assign busy       = !idle;
  assign req0_ready = idle && (prio || !req1_valid);
  assign req1_ready = idle && (!prio || !req0_valid);
  assign take0      = req0_valid && req0_ready;
  assign take1      = req1_valid && req1_ready;
  assign take       = take0 || take1;
  assign in_op      = take1 ? req1_op : req0_op;
  assign in_a       = take1 ? req1_a : req0_a;
  assign in_b       = take1 ? req1_b : req0_b;

  assign ax   = {{WIDTH{1'b0}}, a};
  assign part = b[cnt] ? (ax << cnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (take)
          state_n = (in_op == OP_MUL) ? MUL : EXEC;
      end
      EXEC:    state_n = IDLE;
      MUL:     if (mdone) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // SUB carry is the raw carry-out of A+~B+1, so 1 means no borrow.
  always_comb begin
    sum = '0;
    res = '0;
    cy  = 1'b0;
    unique case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: res = a ^ b;
      3'b011: res = ~a;
      3'b100: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
      end
      3'b101: begin
        sum = {1'b0, a} + {1'b0, ~b}
            + {{WIDTH{1'b0}}, 1'b1};
        res = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
      end
      3'b110: begin
        res = acc[WIDTH-1:0];
        cy  = |acc[2*WIDTH-1:WIDTH];
      end
      default: res = b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 1'b1;
      own         <= 1'b0;
      mdone       <= 1'b0;
      op          <= '0;
      a           <= '0;
      b           <= '0;
      acc         <= '0;
      cnt         <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= '0;
      resp_flags  <= '0;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (idle && take) begin
        own   <= take1;
        prio  <= take1;
        op    <= in_op;
        a     <= in_a;
        b     <= in_b;
        acc   <= '0;
        cnt   <= '0;
        mdone <= 1'b0;
      end else if (state == MUL && !mdone) begin
        acc <= acc + part;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1))
          mdone <= 1'b1;
      end else if (!idle) begin
        resp_data   <= res;
        resp_flags  <= {cy, res == '0};
        resp0_valid <= !own;
        resp1_valid <= own;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: cycle model of the arbiter
// and ALU results, plus literal expectations on the directed ops.
module tb_alu_share_arb;

  localparam logic [2:0] AND_ = 3'b000;
  localparam logic [2:0] OR_  = 3'b001;
  localparam logic [2:0] XOR_ = 3'b010;
  localparam logic [2:0] NOT_ = 3'b011;
  localparam logic [2:0] ADD_ = 3'b100;
  localparam logic [2:0] SUB_ = 3'b101;
  localparam logic [2:0] MUL_ = 3'b110;
  localparam logic [2:0] PSB_ = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [2:0]  req0_op = '0;
  logic [2:0]  req1_op = '0;
  logic [15:0] req0_a = '0;
  logic [15:0] req0_b = '0;
  logic [15:0] req1_a = '0;
  logic [15:0] req1_b = '0;
  logic        req0_ready;
  logic        req1_ready;
  logic        resp0_valid;
  logic        resp1_valid;
  logic [15:0] resp_data;
  logic [1:0]  resp_flags;
  logic        busy;

  alu_share_arb #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op(req0_op),
    .req0_a(req0_a),
    .req0_b(req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op(req1_op),
    .req1_a(req1_a),
    .req1_b(req1_b),
    .resp0_valid(resp0_valid),
    .resp1_valid(resp1_valid),
    .resp_data(resp_data),
    .resp_flags(resp_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Result model straight from the opcode table.
  function automatic logic [17:0] model_alu(
      input logic [2:0] op,
      input logic [15:0] x,
      input logic [15:0] y);
    logic [31:0] p;
    logic [15:0] d;
    logic c;
    p = '0;
    d = '0;
    c = 1'b0;
    case (op)
      AND_: d = x & y;
      OR_:  d = x | y;
      XOR_: d = x ^ y;
      NOT_: d = ~x;
      ADD_: begin
        p = 32'(x) + 32'(y);
        d = p[15:0];
        c = p > 32'hFFFF;
      end
      SUB_: begin
        d = x - y;
        c = x >= y;
      end
      MUL_: begin
        p = 32'(x) * 32'(y);
        d = p[15:0];
        c = p[31:16] != 0;
      end
      default: d = y;
    endcase
    return {d, c, d == 16'h0};
  endfunction

  // Model: remaining = cycles left until the unit frees up.
  int          remaining = 0;
  int          last = 1;
  int          pp = 0;
  bit          pulse = 0;
  bit          started = 0;
  logic [15:0] pd = '0;
  logic [1:0]  pf = '0;
  logic        e_busy;
  logic        e_r0;
  logic        e_r1;
  logic [17:0] r;

  int          seq[$];
  int          pcyc[$];
  logic [15:0] last_d[2];
  logic [1:0]  last_f[2];
  int          n_resp[2];
  int          pulse_cyc[2];

  initial begin
    n_resp[0] = 0;
    n_resp[1] = 0;
    pulse_cyc[0] = 0;
    pulse_cyc[1] = 0;
  end

  always @(negedge clk) begin
    e_busy = remaining > 0;
    e_r0 = !e_busy && (last == 1 || !req1_valid);
    e_r1 = !e_busy && (last == 0 || !req0_valid);
    if (started) begin
      check("ready0", req0_ready, e_r0);
      check("ready1", req1_ready, e_r1);
      check("busy", busy, e_busy);
      check("resp0_valid", resp0_valid, pulse && pp == 0);
      check("resp1_valid", resp1_valid, pulse && pp == 1);
      if (pulse) begin
        check("resp_data", resp_data, pd);
        check("resp_flags", resp_flags, pf);
      end
      if (resp0_valid === 1'b1 || resp1_valid === 1'b1) begin
        int p;
        p = (resp1_valid === 1'b1) ? 1 : 0;
        seq.push_back(p);
        pcyc.push_back(cyc);
        last_d[p] = resp_data;
        last_f[p] = resp_flags;
        n_resp[p]++;
        pulse_cyc[p] = cyc;
      end
    end
    if (rst) begin
      remaining = 0;
      pulse = 0;
      last = 1;
      started = 1;
    end else if (started) begin
      pulse = 0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) pulse = 1;
      end else if (req0_valid && e_r0) begin
        r = model_alu(req0_op, req0_a, req0_b);
        pd = r[17:2];
        pf = r[1:0];
        pp = 0;
        last = 0;
        remaining = (req0_op == MUL_) ? 17 : 1;
      end else if (req1_valid && e_r1) begin
        r = model_alu(req1_op, req1_a, req1_b);
        pd = r[17:2];
        pf = r[1:0];
        pp = 1;
        last = 1;
        remaining = (req1_op == MUL_) ? 17 : 1;
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Hold a request until accepted; ac = cycle index of the accept edge.
  task automatic issue(input int p,
                       input logic [2:0] op,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       output int ac);
    bit rdy;
    int n;
    n = 0;
    ac = -1;
    if (p == 0) begin
      req0_op = op; req0_a = x; req0_b = y;
      req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = x; req1_b = y;
      req1_valid = 1'b1;
    end
    while (ac < 0 && n < 200) begin
      @(negedge clk);
      rdy = (p == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      #1;
      if (rdy) ac = cyc;
      n++;
    end
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    if (ac < 0) begin
      n_tot++;
      $display("FAIL issue_timeout: port %0d never accepted", p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, b0, b1, b2, k, nr;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", resp_data, 16'h0000);
    check("rst_flags", resp_flags, 2'b00);
    check("rst_busy", busy, 1'b0);
    settle(1);

    issue(0, AND_, 16'hF0F0, 16'h0FF0, a0);
    settle(3);
    check("and_data", last_d[0], 16'h00F0);
    check("and_flags", last_f[0], 2'b00);
    check("and_lat", pulse_cyc[0] - a0, 1);

    do_reset();
    k = seq.size();
    fork
      issue(0, ADD_, 16'hFFFF, 16'h0001, a0);
      issue(1, SUB_, 16'h0005, 16'h0007, a1);
    join
    settle(3);
    check("tie_first", seq[k], 0);
    check("add_data", last_d[0], 16'h0000);
    check("add_flags", last_f[0], 2'b11);
    check("sub_data", last_d[1], 16'hFFFE);
    check("sub_flags", last_f[1], 2'b00);

    k = seq.size();
    fork
      begin
        issue(0, XOR_, 16'h1234, 16'hFFFF, a0);
        issue(0, OR_,  16'h1200, 16'h0034, a1);
        issue(0, NOT_, 16'hFFFF, 16'h1111, a2);
      end
      begin
        issue(1, PSB_, 16'hAAAA, 16'h5A5A, b0);
        issue(1, ADD_, 16'h7FFF, 16'h0001, b1);
        issue(1, SUB_, 16'h0009, 16'h0009, b2);
      end
    join
    settle(3);
    check("rr_count", seq.size() - k, 6);
    if (seq.size() >= k + 6) begin
      for (int i = 0; i < 6; i++)
        check("rr_order", seq[k+i], i % 2);
      for (int i = 1; i < 6; i++)
        check("rr_gap", pcyc[k+i] - pcyc[k+i-1], 2);
    end
    check("not_data", last_d[0], 16'h0000);
    check("sub_eq_flags", last_f[1], 2'b11);

    issue(1, MUL_, 16'h0123, 16'h0045, a1);
    settle(19);
    check("mul_data", last_d[1], 16'h4E6F);
    check("mul_flags", last_f[1], 2'b00);
    check("mul_lat", pulse_cyc[1] - a1, 17);

    issue(1, MUL_, 16'h8000, 16'h0002, a1);
    settle(19);
    check("mulov_data", last_d[1], 16'h0000);
    check("mulov_flags", last_f[1], 2'b11);

    issue(1, MUL_, 16'h1111, 16'h00FF, a1);
    nr = n_resp[1];
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    settle(25);
    check("midrst_noresp", n_resp[1], nr);
    k = seq.size();
    fork
      issue(0, AND_, 16'h00FF, 16'h0F0F, a0);
      issue(1, OR_,  16'h0001, 16'h0002, a1);
    join
    settle(3);
    check("postrst_first", seq[k], 0);
    check("postrst_data", last_d[0], 16'h000F);

    fork
      issue(1, MUL_, 16'h0003, 16'h0005, a1);
      begin
        @(posedge clk);
        #1;
        issue(0, ADD_, 16'h0001, 16'h0002, a0);
      end
    join
    settle(3);
    check("hold_acc", a0, pulse_cyc[1] + 1);
    check("hold_resp", pulse_cyc[0], a0 + 1);
    check("hold_mul", last_d[1], 16'h000F);
    check("hold_add", last_d[0], 16'h0003);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
